branch_snapshot_ctrl: RTL and testbench

Checkpoint controller for the register status table. Captures the busy-vector snapshot (`regStatusSnap`) each time a branch passes rename and holds it in a small circular checkpoint buffer. Keeps every live checkpoint current as committing instructions free registers. When a mispredicted branch commits, it drives `statusRestore` and the restore strobe into the register status table. Sits between rename, the ROB commit port and the register status table.

---
 rtl/branch_snapshot_ctrl.sv | 126 ++++++++++++
 tb/tb_branch_snapshot_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_snapshot_ctrl.sv
// Branch checkpoint controller: snapshots the register busy vector per renamed branch,
// keeps live snapshots current with commit-time frees, and restores on a mispredict.
module branch_snapshot_ctrl #(
   parameter int unsigned WIDTH = 31,
   parameter int unsigned REG   = 4,
   parameter int unsigned ROB   = 2,
   parameter int unsigned SIDX  = 1
) (
   input  logic             clk,
   input  logic             globalReset,
   input  logic             branchRename,
   input  logic [ROB:0]     branchROB,
   input  logic [WIDTH:0]   regStatusSnap,
   input  logic             freeValid,
   input  logic [REG:0]     freeReg,
   input  logic             validCommit,
   input  logic [ROB:0]     commitROB,
   input  logic             mispredict,
   output logic             snapGrant,
   output logic             snapFull,
   output logic             restoreValid,
   output logic [WIDTH:0]   statusRestore,
   output logic [SIDX+1:0]  snapCount
);

   localparam int unsigned    Depth      = 2 ** (SIDX + 1);
   localparam logic [SIDX+1:0] DepthCount = (SIDX + 2)'(Depth);

   logic [Depth-1:0] valid_q, valid_d;
   logic [ROB:0]     tag_q [Depth];
   logic [ROB:0]     tag_d [Depth];
   logic [WIDTH:0]   vec_q [Depth];
   logic [WIDTH:0]   vec_d [Depth];
   logic [SIDX:0]    head_q, head_d;
   logic [SIDX:0]    tail_q, tail_d;
   logic [SIDX+1:0]  count_q, count_d;
   logic             full_q, full_d;

   logic             head_hit;
   logic             pop;
   logic             grant;
   logic             restore;
   logic [WIDTH:0]   free_mask;

   // Register freed this cycle; applied to stored, captured and restored vectors alike.
   always_comb begin
      free_mask = '1;
      if (freeValid) begin
         free_mask[freeReg] = 1'b0;
      end
   end

   assign head_hit = validCommit & valid_q[head_q] & (commitROB == tag_q[head_q]);
   assign restore  = head_hit & mispredict & ~globalReset;
   assign pop      = head_hit & ~mispredict;
   // Fullness is the registered view only; a same-cycle pop does not free a slot.
   assign grant    = branchRename & ~full_q & ~restore & ~globalReset;

   assign snapGrant     = grant;
   assign restoreValid  = restore;
   assign statusRestore = restore ? (vec_q[head_q] & free_mask) : '0;
   assign snapFull      = full_q;
   assign snapCount     = count_q;

   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      vec_d   = vec_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q + {{(SIDX + 1){1'b0}}, grant} - {{(SIDX + 1){1'b0}}, pop};

      for (int unsigned i = 0; i < Depth; i++) begin
         if (valid_q[i]) begin
            vec_d[i] = vec_q[i] & free_mask;
         end
      end

      if (restore) begin
         valid_d = '0;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         // Grant and pop never hit the same slot: grant needs a non-full buffer and
         // pop a non-empty one, so head and tail differ whenever both fire.
         if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
         end
         if (grant) begin
            valid_d[tail_q] = 1'b1;
            tag_d[tail_q]   = branchROB;
            vec_d[tail_q]   = regStatusSnap & free_mask;
            tail_d          = tail_q + 1'b1;
         end
      end

      full_d = (count_d == DepthCount);
   end

   always_ff @(posedge clk) begin
      if (globalReset) begin
         valid_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
         for (int unsigned i = 0; i < Depth; i++) begin
            tag_q[i] <= '0;
            vec_q[i] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         full_q  <= full_d;
         for (int unsigned i = 0; i < Depth; i++) begin
            tag_q[i] <= tag_d[i];
            vec_q[i] <= vec_d[i];
         end
      end
   end

endmodule

// File: tb/tb_branch_snapshot_ctrl.sv
// Bench for branch_snapshot_ctrl: directed scenarios plus random traffic, all checked
// against a queue-of-snapshots model of the checkpoint buffer.
module tb_branch_snapshot_ctrl;

   localparam int WIDTH = 31;
   localparam int REG   = 4;
   localparam int ROB   = 2;
   localparam int SIDX  = 1;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             globalReset, branchRename, freeValid, validCommit, mispredict;
   logic [ROB:0]     branchROB, commitROB;
   logic [WIDTH:0]   regStatusSnap;
   logic [REG:0]     freeReg;
   logic             snapGrant, snapFull, restoreValid;
   logic [WIDTH:0]   statusRestore;
   logic [SIDX+1:0]  snapCount;

   branch_snapshot_ctrl #(.WIDTH(WIDTH), .REG(REG), .ROB(ROB), .SIDX(SIDX)) dut (
      .clk           (clk),
      .globalReset   (globalReset),
      .branchRename  (branchRename),
      .branchROB     (branchROB),
      .regStatusSnap (regStatusSnap),
      .freeValid     (freeValid),
      .freeReg       (freeReg),
      .validCommit   (validCommit),
      .commitROB     (commitROB),
      .mispredict    (mispredict),
      .snapGrant     (snapGrant),
      .snapFull      (snapFull),
      .restoreValid  (restoreValid),
      .statusRestore (statusRestore),
      .snapCount     (snapCount)
   );

   typedef struct {
      logic [ROB:0]   tag;
      logic [WIDTH:0] vec;
   } snap_t;

   snap_t          q[$];      // live checkpoints, oldest first
   int             n_vec = 0;
   int             n_err = 0;
   logic           e_grant, e_rv, e_hit, e_pop;
   logic [WIDTH:0] e_sr, e_fb;

   // Expected combinational outputs for the inputs currently driven.
   function automatic void model_eval();
      e_fb = '0;
      if (freeValid) e_fb[freeReg] = 1'b1;
      e_hit = 1'b0;
      if (validCommit && q.size() > 0) e_hit = (q[0].tag == commitROB);
      e_rv    = e_hit && mispredict && !globalReset;
      e_pop   = e_hit && !mispredict;
      e_sr    = e_rv ? (q[0].vec & ~e_fb) : '0;
      e_grant = branchRename && (q.size() < DEPTH) && !e_rv && !globalReset;
   endfunction

   task automatic tick();
      model_eval();
      @(posedge clk);
      #1;
      if (globalReset || e_rv) begin
         q.delete();
      end else begin
         foreach (q[i]) q[i].vec = q[i].vec & ~e_fb;
         if (e_pop) void'(q.pop_front());
         if (e_grant) q.push_back('{tag: branchROB, vec: regStatusSnap & ~e_fb});
      end
   endtask

   task automatic idle();
      globalReset   = 1'b0;
      branchRename  = 1'b0;
      branchROB     = '0;
      regStatusSnap = '0;
      freeValid     = 1'b0;
      freeReg       = '0;
      validCommit   = 1'b0;
      commitROB     = '0;
      mispredict    = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      globalReset = 1'b1;
      tick();
      globalReset = 1'b0;
   endtask

   task automatic test_reset();
      for (int c = 0; c < 2; c++) begin
         idle();
         globalReset   = 1'b1;
         branchRename  = 1'b1;
         regStatusSnap = 32'hFFFF_FFFF;
         validCommit   = 1'b1;
         mispredict    = 1'b1;
         #2;
         n_vec++;
         if (snapGrant !== 1'b0) begin
            n_err++; $display("FAIL reset_grant: got %b want 0", snapGrant);
         end
         n_vec++;
         if (restoreValid !== 1'b0 || statusRestore !== '0) begin
            n_err++;
            $display("FAIL reset_restore: got %b/%h want 0/0", restoreValid, statusRestore);
         end
         tick();
      end
      idle();
      #2;
      n_vec++;
      if (snapCount !== 3'd0 || snapFull !== 1'b0) begin
         n_err++; $display("FAIL reset_state: got count %0d full %b want 0 0", snapCount, snapFull);
      end
      n_vec++;
      if (restoreValid !== 1'b0 || statusRestore !== '0) begin
         n_err++;
         $display("FAIL reset_idle_restore: got %b/%h want 0/0", restoreValid, statusRestore);
      end
      tick();
   endtask

   task automatic test_fill_full();
      do_reset();
      for (int k = 1; k <= 4; k++) begin
         idle();
         branchRename  = 1'b1;
         branchROB     = 3'(k);
         regStatusSnap = 32'h0000_00F0;
         #2;
         n_vec++;
         if (snapGrant !== 1'b1) begin
            n_err++; $display("FAIL fill_grant%0d: got %b want 1", k, snapGrant);
         end
         tick();
      end
      branchROB = 3'd5;
      #2;
      n_vec++;
      if (snapFull !== 1'b1 || snapCount !== 3'd4) begin
         n_err++; $display("FAIL fill_full: got full %b count %0d want 1 4", snapFull, snapCount);
      end
      n_vec++;
      if (snapGrant !== 1'b0) begin
         n_err++; $display("FAIL fill_grant5: got %b want 0", snapGrant);
      end
      tick();
   endtask

   task automatic test_free_restore();
      do_reset();
      idle();
      branchRename  = 1'b1;
      branchROB     = 3'd3;
      regStatusSnap = 32'h0000_00F0;
      tick();
      idle();
      freeValid = 1'b1;
      freeReg   = 5'd5;
      tick();
      idle();
      validCommit = 1'b1;
      commitROB   = 3'd3;
      mispredict  = 1'b1;
      #2;
      n_vec++;
      if (restoreValid !== 1'b1 || statusRestore !== 32'h0000_00D0) begin
         n_err++;
         $display("FAIL free_restore: got %b/%h want 1/000000d0", restoreValid, statusRestore);
      end
      tick();
      idle();
      #2;
      n_vec++;
      if (snapCount !== 3'd0) begin
         n_err++; $display("FAIL restore_empty: got count %0d want 0", snapCount);
      end
      tick();
   endtask

   task automatic test_pop_wrap();
      logic seen_rv;
      do_reset();
      seen_rv = 1'b0;
      for (int k = 0; k < 6; k++) begin
         idle();
         branchRename  = 1'b1;
         branchROB     = 3'(k + 1);
         regStatusSnap = $urandom;
         #2;
         n_vec++;
         if (snapGrant !== 1'b1) begin
            n_err++; $display("FAIL wrap_grant%0d: got %b want 1", k, snapGrant);
         end
         tick();
         idle();
         validCommit = 1'b1;
         commitROB   = 3'(k + 1);
         #2;
         if (restoreValid) seen_rv = 1'b1;
         n_vec++;
         if (snapCount !== 3'd1) begin
            n_err++; $display("FAIL wrap_count%0d: got %0d want 1", k, snapCount);
         end
         tick();
      end
      idle();
      #2;
      n_vec++;
      if (seen_rv !== 1'b0 || snapCount !== 3'd0) begin
         n_err++; $display("FAIL wrap_end: got rv_seen %b count %0d want 0 0", seen_rv, snapCount);
      end
      tick();
   endtask

   task automatic test_simultaneous();
      logic [WIDTH:0] s;
      do_reset();
      for (int k = 1; k <= 4; k++) begin
         idle();
         branchRename  = 1'b1;
         branchROB     = 3'(k);
         regStatusSnap = $urandom;
         tick();
      end
      idle();
      validCommit  = 1'b1;
      commitROB    = 3'd1;
      branchRename = 1'b1;
      branchROB    = 3'd5;
      #2;
      n_vec++;
      if (snapGrant !== 1'b0 || restoreValid !== 1'b0) begin
         n_err++; $display("FAIL sim_pop_grant: got %b/%b want 0/0", snapGrant, restoreValid);
      end
      tick();
      validCommit = 1'b0;
      #2;
      n_vec++;
      if (snapGrant !== 1'b1) begin
         n_err++; $display("FAIL sim_regrant: got %b want 1", snapGrant);
      end
      tick();
      idle();
      #2;
      n_vec++;
      if (snapCount !== 3'd4 || snapFull !== 1'b1) begin
         n_err++; $display("FAIL sim_count: got %0d/%b want 4/1", snapCount, snapFull);
      end
      tick();

      do_reset();
      s = $urandom;
      idle();
      branchRename  = 1'b1;
      branchROB     = 3'd2;
      regStatusSnap = s;
      tick();
      idle();
      validCommit  = 1'b1;
      commitROB    = 3'd2;
      mispredict   = 1'b1;
      branchRename = 1'b1;
      branchROB    = 3'd4;
      #2;
      n_vec++;
      if (snapGrant !== 1'b0 || restoreValid !== 1'b1 || statusRestore !== s) begin
         n_err++;
         $display("FAIL sim_restore: got g%b rv%b %h want g0 rv1 %h",
                  snapGrant, restoreValid, statusRestore, s);
      end
      tick();
      idle();
      #2;
      n_vec++;
      if (snapCount !== 3'd0) begin
         n_err++; $display("FAIL sim_restore_empty: got %0d want 0", snapCount);
      end
      tick();
   endtask

   task automatic test_nonmatch();
      logic [WIDTH:0] s;
      do_reset();
      s = $urandom;
      idle();
      branchRename  = 1'b1;
      branchROB     = 3'd2;
      regStatusSnap = s;
      tick();
      idle();
      validCommit = 1'b1;
      commitROB   = 3'd6;
      mispredict  = 1'b1;
      #2;
      n_vec++;
      if (restoreValid !== 1'b0 || statusRestore !== '0) begin
         n_err++;
         $display("FAIL nonmatch_rv: got %b/%h want 0/0", restoreValid, statusRestore);
      end
      tick();
      commitROB = 3'd2;
      #2;
      n_vec++;
      if (snapCount !== 3'd1 || restoreValid !== 1'b1 || statusRestore !== s) begin
         n_err++;
         $display("FAIL nonmatch_state: got count %0d rv %b %h want 1 1 %h",
                  snapCount, restoreValid, statusRestore, s);
      end
      tick();
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 600; c++) begin
         idle();
         globalReset   = ($urandom_range(49) == 0);
         branchRename  = $urandom_range(1);
         branchROB     = 3'($urandom);
         regStatusSnap = $urandom;
         freeValid     = $urandom_range(1);
         freeReg       = 5'($urandom);
         validCommit   = $urandom_range(1);
         commitROB     = 3'($urandom);
         if (q.size() > 0 && $urandom_range(9) < 7) commitROB = q[0].tag;
         mispredict    = ($urandom_range(4) == 0);
         #2;
         model_eval();
         n_vec++;
         if (snapGrant !== e_grant || restoreValid !== e_rv || statusRestore !== e_sr) begin
            n_err++;
            $display("FAIL rand_comb@%0d: got g%b rv%b %h want g%b rv%b %h", c,
                     snapGrant, restoreValid, statusRestore, e_grant, e_rv, e_sr);
         end
         n_vec++;
         if (snapCount !== 3'(q.size()) || snapFull !== (q.size() == DEPTH)) begin
            n_err++;
            $display("FAIL rand_state@%0d: got count %0d full %b want %0d %b", c,
                     snapCount, snapFull, q.size(), q.size() == DEPTH);
         end
         tick();
      end
   endtask

   initial begin
      idle();
      test_reset();
      test_fill_full();
      test_free_restore();
      test_pop_wrap();
      test_simultaneous();
      test_nonmatch();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
